// File: rtl/lab5_pkg.sv
// rtl/lab5_pkg.sv - shared lab5 loader defaults and FSM state encoding
`ifndef LAB5_PKG_SV
`define LAB5_PKG_SV
package lab5_pkg;

  localparam int LAB5_WORDS  = 128;
  localparam int LAB5_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    FIN
  } lab5_state_t;

endpackage
`endif

// File: rtl/lab5_byte_pack.sv
// rtl/lab5_byte_pack.sv - assembles high then low stream bytes into one 16-bit word
module lab5_byte_pack (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load_hi,
  input  logic        load_lo,
  input  logic [7:0]  din,
  output logic [15:0] word
);

  logic [7:0] hi_q;

  // word only changes when the low byte lands, so it holds steady between writes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hi_q <= '0;
      word <= '0;
    end else begin
      if (load_hi) hi_q <= din;
      if (load_lo) word <= {hi_q, din};
    end
  end

endmodule

// File: rtl/lab5_iram_loader.sv
// rtl/lab5_iram_loader.sv - streams bytes into instruction-memory words through the IRAM write port
module lab5_iram_loader
  import lab5_pkg::*;
#(
  parameter int ADDR_W = LAB5_ADDR_W,
  parameter int WORDS  = LAB5_WORDS
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [6:0]        COUNT,
  input  logic [7:0]        DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [15:0]       WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       CHECKSUM
);

  localparam int IDX_W = $clog2(WORDS);

  lab5_state_t      state, state_n;
  logic [IDX_W-1:0] idx_q;
  logic [6:0]       cnt_q;
  logic             load_hi, load_lo, last;

  assign load_hi = (state == HI) && DIN_VALID;
  assign load_lo = (state == LO) && DIN_VALID;
  // COUNT of 0 wraps to 127 here, which is exactly the last index of a 128-word load
  assign last    = (idx_q == IDX_W'(cnt_q - 7'd1));

  lab5_byte_pack u_pack (
    .CLK     (CLK),
    .RESET   (RESET),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .din     (DIN),
    .word    (WDATA)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    DIN_READY = 1'b0;
    WE        = 1'b0;
    DONE      = 1'b0;
    BUSY      = 1'b1;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) state_n = HI;
      end
      HI: begin
        DIN_READY = 1'b1;
        if (DIN_VALID) state_n = LO;
      end
      LO: begin
        DIN_READY = 1'b1;
        if (DIN_VALID) state_n = WR;
      end
      WR: begin
        WE      = 1'b1;
        state_n = last ? FIN : HI;
      end
      FIN: begin
        DONE    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        BUSY    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      WADDR    <= '0;
      CHECKSUM <= '0;
    end else begin
      if (state == IDLE && START) begin
        cnt_q    <= COUNT;
        idx_q    <= '0;
        CHECKSUM <= '0;
      end
      if (load_lo) WADDR <= ADDR_W'({idx_q, 1'b0});
      if (state == WR) begin
        CHECKSUM <= CHECKSUM + WDATA;
        if (!last) idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/lab5_iram_loader.md
LAB5_IRAM_LOADER -- requirements
Module: lab5_iram_loader

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of the instruction memory write port.
REQ-002 Parameter WORDS, default 128, number of 16-bit instruction words in the target memory.
REQ-003 CLK  input  1  single system clock; all state changes on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 START  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 COUNT  input  7  number of words to load, sampled with START; 0 encodes 128.
REQ-007 DIN  input  8  program byte stream, high byte of each word first.
REQ-008 DIN_VALID  input  1  DIN holds a valid byte.
REQ-009 DIN_READY  output  1  loader accepts DIN this cycle; a byte transfers when DIN_VALID and DIN_READY are both 1 at posedge.
REQ-010 WE  output  1  write strobe to the instruction memory, one cycle per word.
REQ-011 WADDR  output  ADDR_W  byte address of the word being written, always even.
REQ-012 WDATA  output  16  instruction word being written.
REQ-013 BUSY  output  1  load in progress; the core holds its PC and fetch while BUSY is 1.
REQ-014 DONE  output  1  one-cycle pulse after the final word is written.
REQ-015 CHECKSUM  output  16  modulo-2^16 sum of all words written in the current or last load.

Function
REQ-016 FSM states SHALL be IDLE, HI, LO, WR, FIN.
REQ-017 IDLE: DIN_READY=0, BUSY=0; on START, latch COUNT, clear word index and CHECKSUM, go to HI.
REQ-018 HI: DIN_READY=1, BUSY=1; on handshake, store DIN as WDATA[15:8], go to LO; otherwise stay.
REQ-019 LO: DIN_READY=1, BUSY=1; on handshake, store DIN as WDATA[7:0], go to WR; otherwise stay.
REQ-020 WR: WE=1 for exactly one cycle, DIN_READY=0, WADDR={word_index,1'b0}, CHECKSUM updated with WDATA on the same edge.
REQ-021 WR exit: if word_index equals latched count-1, go to FIN; else increment word_index and go to HI.
REQ-022 FIN: DONE=1 and BUSY=1 for one cycle, then go to IDLE.
REQ-023 Latency: the word write occurs exactly 1 cycle after the low-byte handshake; DONE occurs 1 cycle after the last WE.
REQ-024 START in any state other than IDLE SHALL be ignored.
REQ-025 DIN_VALID while DIN_READY=0 SHALL be ignored, and no byte SHALL be consumed.
REQ-026 COUNT=0 SHALL load 128 words, addresses 0x00..0xFE; word_index SHALL never wrap past WORDS-1.
REQ-027 WE, DONE and DIN_READY SHALL be driven from state only (Moore) and SHALL NOT depend combinationally on DIN_VALID.
REQ-028 WADDR and WDATA SHALL hold their values between writes; CHECKSUM SHALL hold its value after FIN until the next START.

Reset
REQ-029 On RESET the FSM SHALL go to IDLE, with WE=0, DONE=0, BUSY=0, DIN_READY=0, WADDR=0, WDATA=0, CHECKSUM=0, and word_index=0.
REQ-030 RESET during HI, LO or WR SHALL abort the load with no further WE; a partially assembled word SHALL be discarded.
REQ-031 RESET SHALL take priority over START in the same cycle.

Structure
REQ-032 The state encoding and the WORDS and ADDR_W defaults SHALL live in a shared lab5 package/header, guarded with an include guard.
REQ-033 The module SHALL have one natural sub-module, lab5_byte_pack, which assembles the high and low bytes into a 16-bit word; all other logic SHALL be in the top level.
REQ-034 The block SHALL connect to a write port (WE/WADDR/WDATA) of the instruction memory, using the same word-select convention of ADDR[7:1].

Verification
REQ-035 Reset, then START with COUNT=2 and bytes F4,91,F2,49 with VALID held high -> writes (0x00,F491) and (0x02,F249), DONE pulses, CHECKSUM=E6DA.
REQ-036 COUNT=1 with DIN_VALID toggling 1,0,1 -> stalls in LO with no WE until the second byte; one write of the correct word; DONE exactly one cycle after WE.
REQ-037 COUNT=0 with 256 incrementing bytes -> 128 writes, last at WADDR=0xFE, no WADDR wrap, DONE once.
REQ-038 A second START pulsed during a COUNT=3 load -> ignored; exactly 3 writes; word index unaffected.
REQ-039 RESET asserted in LO of word 1 during a COUNT=4 load -> no further WE, BUSY=0 and CHECKSUM=0 next cycle; a new START with COUNT=1 loads at WADDR=0x00.
REQ-040 DIN_VALID high while in IDLE or WR -> no byte consumed and DIN_READY=0 throughout.
